// File: rtl/leitor_musica.sv
// ----------------------------------------------------------------------------
// leitor_musica -- song playback sequencer.
//
// Walks the words of one song in the external 16 x 32 note/tempo memory. The
// memory has one cycle of synchronous read latency. Each note is held for
// 'tempo' units of TICKS_POR_UNIDADE clock cycles. Playback stops at the
// end-of-song marker or after word 31.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   iniciar        start pulse, accepted only when idle
//   parar          synchronous abort, accepted in any state
//   pausa          level, freezes note timing while high
//   musica_sel     song to play, sampled when iniciar is accepted
//   nota_mem       memory note output
//   tempo_mem      memory tempo output
//   fim_musica_mem memory end-of-song marker
//   musica, addr   registered song select and word address to the memory
//   nota_atual     note currently playing (0 = rest)
//   tocando        sound enable for the tone generator
//   ocupado        high whenever the sequencer is not idle
//   fim            one-cycle pulse on normal song completion
// ----------------------------------------------------------------------------
module leitor_musica #(
   parameter int TICKS_POR_UNIDADE = 12500000,
   parameter int CONT_WIDTH        = $clog2(TICKS_POR_UNIDADE)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       parar,
   input  logic       pausa,
   input  logic [3:0] musica_sel,
   input  logic [3:0] nota_mem,
   input  logic [3:0] tempo_mem,
   input  logic       fim_musica_mem,
   output logic [3:0] musica,
   output logic [4:0] addr,
   output logic [3:0] nota_atual,
   output logic       tocando,
   output logic       ocupado,
   output logic       fim
);

   typedef enum logic [2:0] {OCIOSO, BUSCA, CARREGA, TOCA, FIM} estado_t;

   localparam logic [CONT_WIDTH-1:0] TICK_MAX = CONT_WIDTH'(TICKS_POR_UNIDADE - 1);

   estado_t               estado_q, estado_d;
   logic [3:0]            musica_q, musica_d;
   logic [4:0]            addr_q, addr_d;
   logic [3:0]            nota_q, nota_d;
   logic                  tocando_q, tocando_d;
   logic                  fim_q, fim_d;
   logic [CONT_WIDTH-1:0] tick_q, tick_d;
   logic [3:0]            unid_q, unid_d;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the
      // case statement leaves one unassigned, which would infer a latch.
      estado_d  = estado_q;
      musica_d  = musica_q;
      addr_d    = addr_q;
      nota_d    = nota_q;
      tocando_d = tocando_q;
      fim_d     = 1'b0;
      tick_d    = tick_q;
      unid_d    = unid_q;

      if (parar) begin
         // Abort: silent return to idle, address and song kept for inspection.
         estado_d  = OCIOSO;
         nota_d    = 4'd0;
         tocando_d = 1'b0;
         tick_d    = '0;
         unid_d    = 4'd0;
      end else begin
         unique case (estado_q)
            OCIOSO: begin
               if (iniciar) begin
                  musica_d = musica_sel;
                  addr_d   = 5'd0;
                  estado_d = BUSCA;
               end
            end
            BUSCA: estado_d = CARREGA;   // memory is registering addr
            CARREGA: begin
               if (fim_musica_mem) begin
                  estado_d = FIM;
                  fim_d    = 1'b1;       // fim is high while in FIM
               end else begin
                  nota_d    = nota_mem;
                  tocando_d = (nota_mem != 4'd0);
                  unid_d    = (tempo_mem == 4'd0) ? 4'd1 : tempo_mem;
                  tick_d    = '0;
                  estado_d  = TOCA;
               end
            end
            TOCA: begin
               if (!pausa) begin
                  if (tick_q == TICK_MAX) begin
                     tick_d = '0;
                     unid_d = unid_q - 4'd1;
                     if (unid_q == 4'd1) begin
                        if (addr_q == 5'd31) begin
                           estado_d = FIM;  // no wrap past the last word
                           fim_d    = 1'b1;
                        end else begin
                           addr_d   = addr_q + 5'd1;
                           estado_d = BUSCA;
                        end
                     end
                  end else begin
                     tick_d = CONT_WIDTH'(tick_q + 1);
                  end
               end
            end
            FIM: begin
               nota_d    = 4'd0;
               tocando_d = 1'b0;
               estado_d  = OCIOSO;
            end
            default: estado_d = OCIOSO;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q  <= OCIOSO;
         musica_q  <= 4'd0;
         addr_q    <= 5'd0;
         nota_q    <= 4'd0;
         tocando_q <= 1'b0;
         fim_q     <= 1'b0;
         tick_q    <= '0;
         unid_q    <= 4'd0;
      end else begin
         estado_q  <= estado_d;
         musica_q  <= musica_d;
         addr_q    <= addr_d;
         nota_q    <= nota_d;
         tocando_q <= tocando_d;
         fim_q     <= fim_d;
         tick_q    <= tick_d;
         unid_q    <= unid_d;
      end
   end

   assign musica     = musica_q;
   assign addr       = addr_q;
   assign nota_atual = nota_q;
   assign tocando    = tocando_q & ~pausa;   // pause mutes immediately
   assign ocupado    = (estado_q != OCIOSO);
   assign fim        = fim_q;

endmodule

// File: tb/tb_leitor_musica.sv
// ----------------------------------------------------------------------------
// tb_leitor_musica -- self-checking bench for leitor_musica.
//
// A behavioural 1-cycle-latency song memory feeds the DUT. For each directed
// step the bench queues one vector per clock cycle: the inputs to drive and
// the outputs expected in that cycle, derived from the song contents. The
// drain task applies each vector and compares the observed outputs.
// ----------------------------------------------------------------------------
module tb_leitor_musica;

   localparam int TICKS = 4;

   logic       clk = 1'b0;
   logic       reset, iniciar, parar, pausa;
   logic [3:0] musica_sel, nota_mem, tempo_mem;
   logic       fim_musica_mem;
   logic [3:0] musica;
   logic [4:0] addr;
   logic [3:0] nota_atual;
   logic       tocando, ocupado, fim;

   leitor_musica #(.TICKS_POR_UNIDADE(TICKS)) dut (
      .clk(clk), .reset(reset), .iniciar(iniciar), .parar(parar), .pausa(pausa),
      .musica_sel(musica_sel), .nota_mem(nota_mem), .tempo_mem(tempo_mem),
      .fim_musica_mem(fim_musica_mem), .musica(musica), .addr(addr),
      .nota_atual(nota_atual), .tocando(tocando), .ocupado(ocupado), .fim(fim)
   );

   always #5 clk = ~clk;

   // Behavioural song memory, one cycle of read latency.
   logic [3:0] mem_n [16][32];
   logic [3:0] mem_t [16][32];

   always_ff @(posedge clk) begin
      nota_mem       <= mem_n[musica][addr];
      tempo_mem      <= mem_t[musica][addr];
      fim_musica_mem <= (mem_n[musica][addr] == 4'd0) && (mem_t[musica][addr] == 4'd0);
   end

   typedef struct packed {
      logic [3:0] musica;
      logic [4:0] addr;
      logic [3:0] nota;
      logic       toc;
      logic       ocu;
      logic       fim;
   } out_t;

   typedef struct {
      string      tag;
      logic       rst, ini, par, pau;
      logic [3:0] sel;
      out_t       exp;
   } vec_t;

   vec_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Expected registered outputs, tracked by the step generators.
   logic [3:0] e_mus  = 4'd0;
   logic [4:0] e_addr = 5'd0;
   logic [3:0] e_nota = 4'd0;
   logic       e_toc  = 1'b0;

   task automatic push(input string tag, input logic rst, input logic ini,
                       input logic par, input logic pau, input logic [3:0] sel,
                       input logic toc, input logic ocu, input logic fim_e);
      vec_t v;
      v.tag = tag;
      v.rst = rst;
      v.ini = ini;
      v.par = par;
      v.pau = pau;
      v.sel = sel;
      v.exp = '{musica: e_mus, addr: e_addr, nota: e_nota, toc: toc, ocu: ocu, fim: fim_e};
      sb.push_back(v);
   endtask

   task automatic drain();
      vec_t v;
      out_t obs;
      while (sb.size() > 0) begin
         v = sb.pop_front();
         @(negedge clk);
         reset      = v.rst;
         iniciar    = v.ini;
         parar      = v.par;
         pausa      = v.pau;
         musica_sel = v.sel;
         #1;
         obs = '{musica: musica, addr: addr, nota: nota_atual, toc: tocando,
                 ocu: ocupado, fim: fim};
         vectors++;
         assert (obs === v.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h (musica,addr,nota,toc,ocu,fim)",
                   v.tag, obs, v.exp);
         end
      end
   endtask

   // Queue the cycle-by-cycle expectation for playing song s.
   //   pw/pa/pl : pause word, TOCA cycle at which pausa rises, pause length
   //   ev_kind  : 0 none, 1 parar, 2 reset, asserted at TOCA cycle ev_a of word ev_w
   //   ign      : cycle index (from BUSCA of word 0) carrying an ignored iniciar
   task automatic gen_song(input int s, input int pw, input int pa, input int pl,
                           input int ev_kind, input int ev_w, input int ev_a,
                           input int ign);
      int         cyc;
      int         units;
      int         len;
      logic [3:0] n, t;
      logic       pz;
      cyc = 0;
      push($sformatf("s%0d start", s), 1'b0, 1'b1, 1'b0, 1'b0, 4'(s), 1'b0, 1'b0, 1'b0);
      e_mus  = 4'(s);
      e_addr = 5'd0;
      for (int w = 0; w < 32; w++) begin
         e_addr = 5'(w);
         push($sformatf("s%0d w%0d busca", s, w), 1'b0, (cyc == ign), 1'b0, 1'b0,
              4'hA, e_toc, 1'b1, 1'b0);
         cyc++;
         push($sformatf("s%0d w%0d carrega", s, w), 1'b0, (cyc == ign), 1'b0, 1'b0,
              4'hA, e_toc, 1'b1, 1'b0);
         cyc++;
         n = mem_n[s][w];
         t = mem_t[s][w];
         if (n == 4'd0 && t == 4'd0) begin
            push($sformatf("s%0d w%0d fim", s, w), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
                 e_toc, 1'b1, 1'b1);
            e_nota = 4'd0;
            e_toc  = 1'b0;
            push($sformatf("s%0d idle", s), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            return;
         end
         e_nota = n;
         e_toc  = (n != 4'd0);
         units  = (t == 4'd0) ? 1 : int'(t);
         len    = units * TICKS + ((w == pw) ? pl : 0);
         for (int j = 0; j < len; j++) begin
            pz = (w == pw) && (j >= pa) && (j < pa + pl);
            if (ev_kind != 0 && w == ev_w && j == ev_a) begin
               push($sformatf("s%0d w%0d abort", s, w), (ev_kind == 2), 1'b0,
                    (ev_kind == 1), 1'b0, 4'h0, e_toc, 1'b1, 1'b0);
               e_nota = 4'd0;
               e_toc  = 1'b0;
               if (ev_kind == 2) begin
                  e_mus  = 4'd0;
                  e_addr = 5'd0;
               end
               push($sformatf("s%0d after abort", s), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
                    1'b0, 1'b0, 1'b0);
               return;
            end
            push($sformatf("s%0d w%0d toca%0d", s, w, j), 1'b0, (cyc == ign), 1'b0, pz,
                 4'hA, e_toc & ~pz, 1'b1, 1'b0);
            cyc++;
         end
      end
      push($sformatf("s%0d fim after w31", s), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
           e_toc, 1'b1, 1'b1);
      e_nota = 4'd0;
      e_toc  = 1'b0;
      push($sformatf("s%0d idle", s), 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int m = 0; m < 16; m++)
         for (int w = 0; w < 32; w++) begin
            mem_n[m][w] = 4'd0;
            mem_t[m][w] = 4'd0;
         end
      mem_n[3][0] = 4'd5; mem_t[3][0] = 4'd2;
      mem_n[3][1] = 4'd7; mem_t[3][1] = 4'd1;
      for (int w = 0; w < 32; w++) begin
         mem_n[5][w] = 4'd1;
         mem_t[5][w] = 4'd1;
      end
      mem_n[6][0] = 4'd9; mem_t[6][0] = 4'd3;
      mem_n[7][0] = 4'd2; mem_t[7][0] = 4'd1;
      mem_n[7][1] = 4'd3; mem_t[7][1] = 4'd1;
      mem_n[7][2] = 4'd4; mem_t[7][2] = 4'd2;
      mem_n[9][0] = 4'd0; mem_t[9][0] = 4'd2;
      mem_n[9][1] = 4'd4; mem_t[9][1] = 4'd0;

      reset      = 1'b1;
      iniciar    = 1'b0;
      parar      = 1'b0;
      pausa      = 1'b0;
      musica_sel = 4'd0;
      repeat (2) @(posedge clk);

      // Reset values.
      push("reset state", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();

      // Two notes then marker.
      gen_song(3, -1, 0, 0, 0, -1, 0, -1);
      drain();

      // Empty song: marker at word 0.
      gen_song(0, -1, 0, 0, 0, -1, 0, -1);
      drain();

      // iniciar together with parar while idle: stays idle.
      push("ini+par idle", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      push("still idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      drain();

      // Full 32-word song, no marker, no wrap.
      gen_song(5, -1, 0, 0, 0, -1, 0, -1);
      drain();

      // Ten-cycle pause in the middle of a three-unit note.
      gen_song(6, 0, 5, 10, 0, -1, 0, -1);
      drain();

      // Abort during word 2, then restart from word 0.
      gen_song(7, -1, 0, 0, 1, 2, 2, -1);
      drain();
      gen_song(7, -1, 0, 0, 0, -1, 0, -1);
      drain();

      // Rest word, zero-tempo note, iniciar ignored while busy.
      gen_song(9, -1, 0, 0, 0, -1, 0, 5);
      drain();

      // Reset in the middle of word 1, then a clean restart.
      gen_song(9, -1, 0, 0, 2, 1, 1, -1);
      drain();
      gen_song(3, -1, 0, 0, 0, -1, 0, -1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
